// File: rtl/phase_sequence_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequence_timer
// Description : Multi-phase down-counting timer with tick enable, pause,
//               skip, start/stop control, optional one-shot mode and
//               phase/cycle completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequence_timer #(
  parameter int NUM_PHASES = 2,
  parameter int WIDTH      = 4,
  parameter int ONE_SHOT   = 0,
  parameter int PW         = $clog2(NUM_PHASES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        pause,
  input  logic                        tick,
  input  logic                        skip,
  input  logic [NUM_PHASES*WIDTH-1:0] phase_len,
  output logic [WIDTH-1:0]            count,
  output logic [PW-1:0]               phase,
  output logic                        phase_done,
  output logic                        cycle_done,
  output logic                        running
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [PW-1:0] C_LAST_PHASE = PW'(NUM_PHASES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_nxt;
  logic [PW-1:0]    w_phase_inc;
  logic             r_phase_done;
  logic             w_phase_done_nxt;
  logic             r_cycle_done;
  logic             w_cycle_done_nxt;
  logic             w_eff_tick;
  logic             w_phase_end;
  logic [WIDTH-1:0] w_len [NUM_PHASES];

  generate
    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_len
      assign w_len[g] = phase_len[g*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_eff_tick  = tick & ~pause;
  // A phase ends on skip, or on an effective tick that finds the counter at zero
  assign w_phase_end = skip | (w_eff_tick & (r_count == '0));
  assign w_phase_inc = r_phase + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_phase      <= '0;
      r_phase_done <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_phase      <= w_phase_nxt;
      r_phase_done <= w_phase_done_nxt;
      r_cycle_done <= w_cycle_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_phase_nxt      = r_phase;
    w_phase_done_nxt = 1'b0;
    w_cycle_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!stop && start) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = '0;
          w_count_nxt = w_len[0];
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
          w_count_nxt = '0;
        end else if (start) begin
          w_phase_nxt = '0;
          w_count_nxt = w_len[0];
        end else if (w_phase_end) begin
          w_phase_done_nxt = 1'b1;
          if (r_phase == C_LAST_PHASE) begin
            w_cycle_done_nxt = 1'b1;
            w_phase_nxt      = '0;
            if (ONE_SHOT != 0) begin
              w_state_nxt = ST_IDLE;
              w_count_nxt = '0;
            end else begin
              w_count_nxt = w_len[0];
            end
          end else begin
            w_phase_nxt = w_phase_inc;
            w_count_nxt = w_len[w_phase_inc];
          end
        end else if (w_eff_tick) begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  assign count      = r_count;
  assign phase      = r_phase;
  assign phase_done = r_phase_done;
  assign cycle_done = r_cycle_done;
  assign running    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_phase_sequence_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequence_timer
// Description : Self-checking bench: a two-phase wrapping timer and a
//               three-phase one-shot timer share control inputs and are
//               compared every cycle against an elapsed-tick reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequence_timer;

  logic       clk;
  logic       reset;
  logic       start, stop, pause, tick, skip;
  logic [3:0] len_a [2];
  logic [3:0] len_b [3];
  logic [7:0] pl_a;
  logic [11:0] pl_b;
  logic [3:0] cnt_a, cnt_b;
  logic       ph_a;
  logic [1:0] ph_b;
  logic       pd_a, pd_b, cd_a, cd_b, run_a, run_b;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a loaded length plus ticks consumed in the current phase
  int m_ph [2];
  int m_lat[2];
  int m_el [2];
  bit m_run[2];
  bit m_pd [2];
  bit m_cd [2];

  assign pl_a = {len_a[1], len_a[0]};
  assign pl_b = {len_b[2], len_b[1], len_b[0]};

  phase_sequence_timer #(.NUM_PHASES(2), .WIDTH(4), .ONE_SHOT(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .tick(tick), .skip(skip), .phase_len(pl_a), .count(cnt_a), .phase(ph_a),
    .phase_done(pd_a), .cycle_done(cd_a), .running(run_a)
  );

  phase_sequence_timer #(.NUM_PHASES(3), .WIDTH(4), .ONE_SHOT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .tick(tick), .skip(skip), .phase_len(pl_b), .count(cnt_b), .phase(ph_b),
    .phase_done(pd_b), .cycle_done(cd_b), .running(run_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int get_len(input int d, input int k);
    if (d == 0) return int'(len_a[k]);
    return int'(len_b[k]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_lat[d] = 0; m_el[d] = 0;
      m_run[d] = 0; m_pd[d] = 0; m_cd[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int np;
    bit one_shot;
    bit eff;
    np       = (d == 0) ? 2 : 3;
    one_shot = (d == 1);
    eff      = tick && !pause;
    m_pd[d]  = 0;
    m_cd[d]  = 0;
    if (stop) begin
      m_run[d] = 0; m_ph[d] = 0; m_lat[d] = 0; m_el[d] = 0;
    end else if (start) begin
      m_run[d] = 1; m_ph[d] = 0; m_lat[d] = get_len(d, 0); m_el[d] = 0;
    end else if (m_run[d]) begin
      if (skip || (eff && m_el[d] == m_lat[d])) begin
        m_pd[d] = 1;
        m_el[d] = 0;
        if (m_ph[d] == np - 1) begin
          m_cd[d] = 1;
          m_ph[d] = 0;
          if (one_shot) begin
            m_run[d] = 0;
            m_lat[d] = 0;
          end else begin
            m_lat[d] = get_len(d, 0);
          end
        end else begin
          m_ph[d]  = m_ph[d] + 1;
          m_lat[d] = get_len(d, m_ph[d]);
        end
      end else if (eff) begin
        m_el[d] = m_el[d] + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("a.count", cnt_a, m_lat[0] - m_el[0]);
    chk("a.phase", ph_a, m_ph[0]);
    chk("a.phase_done", pd_a, m_pd[0]);
    chk("a.cycle_done", cd_a, m_cd[0]);
    chk("a.running", run_a, m_run[0]);
    chk("b.count", cnt_b, m_lat[1] - m_el[1]);
    chk("b.phase", ph_b, m_ph[1]);
    chk("b.phase_done", pd_b, m_pd[1]);
    chk("b.cycle_done", cd_b, m_cd[1]);
    chk("b.running", run_b, m_run[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  initial begin
    int leg [17] = '{5, 4, 3, 2, 1, 0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 5};
    int os_seq [10] = '{2, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    int eff, eff_at, ncd, k;
    bit seen, found;

    reset = 1'b0;
    start = 0; stop = 0; pause = 0; tick = 0; skip = 0;
    len_a[0] = 4'd0; len_a[1] = 4'd0;
    len_b[0] = 4'd0; len_b[1] = 4'd0; len_b[2] = 4'd0;
    model_reset();
    #1;
    check_all();
    repeat (2) cycle();
    reset = 1'b1;
    tick = 1'b1;
    repeat (2) cycle();

    // Legacy equivalence: lengths 5 then 9, tick tied high
    len_a[0] = 4'd5; len_a[1] = 4'd9;
    len_b[0] = 4'd2; len_b[1] = 4'd1; len_b[2] = 4'd0;
    start = 1; cycle(); start = 0;
    chk("legacy.seq0", cnt_a, leg[0]);
    for (int i = 1; i < 17; i++) begin
      cycle();
      chk($sformatf("legacy.seq%0d", i), cnt_a, leg[i]);
      chk($sformatf("legacy.pd%0d", i), pd_a, (i == 6 || i == 16));
      chk($sformatf("legacy.cd%0d", i), cd_a, (i == 16));
    end

    // Tick gating with a pause window inside phase 0
    tick = 0;
    len_a[0] = 4'd3; len_a[1] = 4'd2;
    start = 1; cycle(); start = 0;
    eff = 0; eff_at = -1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick  = (i % 3 == 0);
      pause = (i >= 4 && i <= 8);
      cycle();
      if (tick && !pause && !seen) eff++;
      if (pd_a && !seen) begin
        seen   = 1;
        eff_at = eff;
      end
    end
    tick = 0; pause = 0;
    chk("tick_gate.eff_ticks", eff_at, 4);

    // Skip under pause, then stop+start+skip together
    len_a[0] = 4'd5; len_a[1] = 4'd4;
    start = 1; cycle(); start = 0;
    tick = 1; repeat (3) cycle(); tick = 0;
    chk("skip.pre_count", cnt_a, 2);
    pause = 1; skip = 1; cycle(); skip = 0; pause = 0;
    chk("skip.phase", ph_a, 1);
    chk("skip.count", cnt_a, 4);
    chk("skip.pd", pd_a, 1);
    stop = 1; start = 1; skip = 1; tick = 1; cycle();
    stop = 0; start = 0; skip = 0; tick = 0;
    chk("prio.running", run_a, 0);
    chk("prio.count", cnt_a, 0);

    // One-shot sequence on the three-phase instance
    tick = 1;
    start = 1; cycle(); start = 0;
    ncd = 0;
    chk("oneshot.seq0", cnt_b, os_seq[0]);
    for (int i = 1; i < 10; i++) begin
      cycle();
      if (cd_b) ncd++;
      chk($sformatf("oneshot.seq%0d", i), cnt_b, os_seq[i]);
      chk($sformatf("oneshot.run%0d", i), run_b, (i <= 5));
    end
    chk("oneshot.cd_count", ncd, 1);

    // Mid-phase reload of phase 0, then restart from phase 1
    tick = 0;
    len_a[0] = 4'd5; len_a[1] = 4'd9;
    start = 1; cycle(); start = 0;
    tick = 1; repeat (2) cycle();
    chk("reload.count3", cnt_a, 3);
    len_a[0] = 4'd7;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(pd_a && ph_a == 1'b0) && k < 40);
    chk("reload.wrap_count", cnt_a, 7);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (ph_a == 1'b1 && cnt_a == 4'd4) found = 1;
    end
    chk("restart.reached", found, 1);
    tick = 0;
    start = 1; cycle(); start = 0;
    chk("restart.phase", ph_a, 0);
    chk("restart.count", cnt_a, 7);
    chk("restart.pd", pd_a, 0);

    // Asynchronous reset mid-phase 1
    skip = 1; cycle(); skip = 0;
    tick = 1; repeat (3) cycle(); tick = 0;
    chk("areset.pre_count", cnt_a, 6);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("areset.count", cnt_a, 0);
    chk("areset.phase", ph_a, 0);
    chk("areset.running", run_a, 0);
    check_all();
    tick = 1; skip = 1;
    repeat (3) cycle();
    reset = 1'b1;
    repeat (4) cycle();
    skip = 0;
    repeat (2) cycle();
    tick = 0;

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      r     = $urandom_range(0, 99);
      stop  = (r < 2);
      start = (r >= 2 && r < 7);
      skip  = ($urandom_range(0, 15) == 0);
      tick  = ($urandom_range(0, 3) != 0);
      pause = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) len_a[$urandom_range(0, 1)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) len_b[$urandom_range(0, 2)] = 4'($urandom_range(0, 6));
      cycle();
    end
    start = 0; stop = 0; skip = 0; tick = 0; pause = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
